// File: rtl/spinn_aer_out_mapper.sv
// SpiNNaker multicast packet to parallel AER bus bridge: key/mask filter,
// four-phase active-low REQ/ACK handshake, ACK timeout and saturating counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | post-reset, one cycle, no packets accepted
// S_IDLE  | ready for a packet; mismatches consumed and counted here
// S_SETUP | aer_data settling before REQ falls
// S_REQ   | aer_req low, waiting for synchronized ACK low (or timeout)
// S_REL   | aer_req high, waiting for synchronized ACK high (or timeout)
module spinn_aer_out_mapper #(
  parameter int PKT_BITS = 72,
  parameter int AER_BITS = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PKT_BITS-1:0] opkt_data,
  input  logic                opkt_vld,
  output logic                opkt_rdy,
  input  logic [31:0]         map_key,
  input  logic [31:0]         map_mask,
  output logic [AER_BITS-1:0] aer_data,
  output logic                aer_req,
  input  logic                aer_ack,
  output logic [15:0]         evt_cnt,
  output logic [15:0]         drop_cnt,
  output logic                busy
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_REL
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   key;
  logic [31:0]   addr_full;
  logic          match;
  logic          accept;
  logic          inc_evt;
  logic          inc_drop;
  logic          ack_m;
  logic          ack_s;
  logic [TW-1:0] tmr;
  logic          tmr_tc;
  logic          unused_bits;

  assign key         = opkt_data[39:8];
  assign match       = ((key ^ map_key) & map_mask) == 32'h0;
  assign addr_full   = key & ~map_mask;
  assign unused_bits = ^{opkt_data[PKT_BITS-1:40], opkt_data[7:0], addr_full};

  // ACK idles high, so the synchronizer resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b1;
      ack_s <= 1'b1;
    end else begin
      ack_m <= aer_ack;
      ack_s <= ack_m;
    end
  end

  assign tmr_tc = (tmr == '0);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    inc_evt   = 1'b0;
    inc_drop  = 1'b0;
    case (state)
      S_INIT:  state_nxt = S_IDLE;
      S_IDLE: begin
        if (opkt_vld) begin
          if (match) begin
            accept    = 1'b1;
            state_nxt = S_SETUP;
          end else begin
            inc_drop = 1'b1;
          end
        end
      end
      S_SETUP: state_nxt = S_REQ;
      // ACK takes priority over a coincident timeout
      S_REQ: begin
        if (!ack_s) begin
          inc_evt   = 1'b1;
          state_nxt = S_REL;
        end else if (tmr_tc) begin
          inc_drop  = 1'b1;
          state_nxt = S_REL;
        end
      end
      S_REL:   if (ack_s || tmr_tc) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      tmr      <= TMR_LOAD;
      aer_req  <= 1'b1;
      aer_data <= '0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      aer_req <= (state_nxt != S_REQ);
      // REQ and REL are only ever entered from a different state
      if (state_nxt != state) begin
        tmr <= TMR_LOAD;
      end else if (!tmr_tc) begin
        tmr <= tmr - TW'(1);
      end
      if (accept) begin
        aer_data <= addr_full[AER_BITS-1:0];
      end
      if (inc_evt && (evt_cnt != 16'hFFFF)) begin
        evt_cnt <= evt_cnt + 16'd1;
      end
      if (inc_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign opkt_rdy = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule
